// File: rtl/lsu_ctrl.sv
// Load/store unit controller: one outstanding valid/ready bus access per request,
// with byte-lane steering for stores and aligned, extended load data for write-back.
module lsu_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        mem_rd_ena,
    input  logic        mem_wr_ena,
    input  logic [6:0]  load_info,
    input  logic [3:0]  save_info,
    input  logic [63:0] addr,
    input  logic [63:0] wdata,
    output logic        stall,
    output logic        bus_valid,
    input  logic        bus_ready,
    output logic        bus_we,
    output logic [63:0] bus_addr,
    output logic [63:0] bus_wdata,
    output logic [7:0]  bus_wstrb,
    input  logic        bus_rvalid,
    input  logic [63:0] bus_rdata,
    output logic        resp_valid,
    output logic [63:0] resp_data,
    output logic        resp_err
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_R, RESP} state_t;

    state_t      state_reg;
    logic        is_load_reg;
    logic        sign_reg;
    logic [1:0]  size_reg;
    logic [2:0]  off_reg;

    logic        accept;
    logic [1:0]  size_next;
    logic        sign_next;
    logic        misalign;
    logic        bad_next;
    logic [3:0]  nbytes;
    logic [7:0]  base_strb;
    logic [63:0] shifted;
    logic [63:0] extracted;

    assign accept    = req_valid & (mem_rd_ena | mem_wr_ena);
    assign req_ready = (state_reg == IDLE);
    assign stall     = (state_reg != IDLE) | accept;

    // Size code: 0=byte, 1=half, 2=word, 3=double.
    always_comb begin
        size_next = 2'd0;
        sign_next = 1'b0;
        if (mem_rd_ena) begin
            if (load_info[3])                     size_next = 2'd3;
            else if (load_info[2] | load_info[6]) size_next = 2'd2;
            else if (load_info[1] | load_info[5]) size_next = 2'd1;
            sign_next = |load_info[2:0];
        end else begin
            if (save_info[3])      size_next = 2'd3;
            else if (save_info[2]) size_next = 2'd2;
            else if (save_info[1]) size_next = 2'd1;
        end
    end

    always_comb begin
        case (size_next)
            2'd1:    misalign = addr[0];
            2'd2:    misalign = |addr[1:0];
            2'd3:    misalign = |addr[2:0];
            default: misalign = 1'b0;
        endcase
    end

    assign bad_next = (mem_rd_ena & mem_wr_ena)
                    | (mem_rd_ena & ~$onehot(load_info))
                    | (mem_wr_ena & ~$onehot(save_info))
                    | misalign;

    assign nbytes = 4'd1 << size_next;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_strb
            assign base_strb[gi] = (4'(gi) < nbytes);
        end
    endgenerate

    assign shifted = bus_rdata >> {off_reg, 3'b000};

    always_comb begin
        case (size_reg)
            2'd0:    extracted = sign_reg ? {{56{shifted[7]}},  shifted[7:0]}  : {56'd0, shifted[7:0]};
            2'd1:    extracted = sign_reg ? {{48{shifted[15]}}, shifted[15:0]} : {48'd0, shifted[15:0]};
            2'd2:    extracted = sign_reg ? {{32{shifted[31]}}, shifted[31:0]} : {32'd0, shifted[31:0]};
            default: extracted = shifted;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            is_load_reg <= 1'b0;
            sign_reg    <= 1'b0;
            size_reg    <= 2'd0;
            off_reg     <= 3'd0;
            bus_valid   <= 1'b0;
            bus_we      <= 1'b0;
            bus_addr    <= 64'd0;
            bus_wdata   <= 64'd0;
            bus_wstrb   <= 8'd0;
            resp_valid  <= 1'b0;
            resp_data   <= 64'd0;
            resp_err    <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        is_load_reg <= mem_rd_ena;
                        sign_reg    <= sign_next;
                        size_reg    <= size_next;
                        off_reg     <= addr[2:0];
                        bus_addr    <= {addr[63:3], 3'b000};
                        bus_we      <= mem_wr_ena & ~mem_rd_ena;
                        bus_wdata   <= wdata << {addr[2:0], 3'b000};
                        bus_wstrb   <= (mem_wr_ena & ~mem_rd_ena) ? (base_strb << addr[2:0]) : 8'd0;
                        resp_data   <= 64'd0;
                        if (bad_next) begin
                            state_reg  <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                        end else begin
                            state_reg  <= REQ;
                            bus_valid  <= 1'b1;
                            resp_err   <= 1'b0;
                        end
                    end
                end
                REQ: begin
                    if (bus_ready) begin
                        bus_valid <= 1'b0;
                        if (is_load_reg) begin
                            state_reg <= WAIT_R;
                        end else begin
                            state_reg  <= RESP;
                            resp_valid <= 1'b1;
                        end
                    end
                end
                WAIT_R: begin
                    if (bus_rvalid) begin
                        resp_data  <= extracted;
                        resp_valid <= 1'b1;
                        state_reg  <= RESP;
                    end
                end
                RESP: begin
                    state_reg <= IDLE;
                    resp_err  <= 1'b0;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: stimulus queues expected bus requests and responses,
// negedge monitors compare them whenever the DUT presents bus_valid or resp_valid.
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, mem_rd_ena, mem_wr_ena;
    logic [6:0]  load_info;
    logic [3:0]  save_info;
    logic [63:0] addr, wdata;
    logic        stall, bus_valid, bus_ready, bus_we;
    logic [63:0] bus_addr, bus_wdata;
    logic [7:0]  bus_wstrb;
    logic        bus_rvalid;
    logic [63:0] bus_rdata;
    logic        resp_valid;
    logic [63:0] resp_data;
    logic        resp_err;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic stall_win = 1'b0;
    int stall_cnt = 0;

    typedef struct { logic [63:0] data; logic err; int cyc; } resp_t;
    typedef struct { logic [63:0] addr; logic we; logic [63:0] wdata; logic [7:0] strb; } bus_t;
    resp_t exp_resp[$];
    bus_t  exp_bus[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lsu_ctrl dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .mem_rd_ena(mem_rd_ena), .mem_wr_ena(mem_wr_ena), .load_info(load_info),
        .save_info(save_info), .addr(addr), .wdata(wdata), .stall(stall),
        .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
        .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata), .resp_valid(resp_valid),
        .resp_data(resp_data), .resp_err(resp_err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Response monitor
    always @(negedge clk) begin
        resp_t e;
        if (resp_valid) begin
            if (exp_resp.size() == 0) begin
                check("resp_unexpected", 64'(resp_valid), 64'd0);
            end else begin
                e = exp_resp.pop_front();
                check("resp_data", resp_data, e.data);
                check("resp_err", 64'(resp_err), 64'(e.err));
                check("resp_cycle", 64'(cyc), 64'(e.cyc));
                $display("resp: data=%h err=%0d cycle=%0d", resp_data, resp_err, cyc);
            end
        end
    end

    // Bus monitor: every bus_valid cycle must show the stable expected request
    always @(negedge clk) begin
        bus_t b;
        logic [63:0] m;
        if (bus_valid) begin
            if (exp_bus.size() == 0) begin
                check("bus_unexpected", 64'(bus_valid), 64'd0);
            end else begin
                b = exp_bus[0];
                m = 64'd0;
                for (int i = 0; i < 8; i++) if (b.strb[i]) m[i*8 +: 8] = 8'hFF;
                check("bus_addr", bus_addr, b.addr);
                check("bus_we", 64'(bus_we), 64'(b.we));
                check("bus_wstrb", 64'(bus_wstrb), 64'(b.strb));
                check("bus_wdata", bus_wdata & m, b.wdata);
                $display("bus: addr=%h we=%0d strb=%h ready=%0d", bus_addr, bus_we, bus_wstrb, bus_ready);
                if (bus_ready) void'(exp_bus.pop_front());
            end
        end
    end

    always @(negedge clk) if (stall_win && stall) stall_cnt++;

    // Issue one access from an IDLE cycle (#1 after posedge) and serve the bus;
    // returns #1 after the posedge that re-enters IDLE.
    task automatic run(input logic rd, input logic wr, input logic [6:0] li, input logic [3:0] si,
                       input logic [63:0] a, input logic [63:0] wd, input int nready, input int nrvalid,
                       input logic [63:0] rdata, input logic exp_err, input logic [63:0] exp_data,
                       input logic [63:0] exp_baddr, input logic [7:0] exp_strb, input logic [63:0] exp_wdata);
        resp_t r;
        bus_t  b;
        int    lat;
        lat = exp_err ? 1 : ((rd ? 3 : 2) + nready + (rd ? nrvalid : 0));
        r.data = exp_data; r.err = exp_err; r.cyc = cyc + lat;
        exp_resp.push_back(r);
        if (!exp_err) begin
            b.addr = exp_baddr; b.we = wr; b.wdata = exp_wdata; b.strb = exp_strb;
            exp_bus.push_back(b);
        end
        check("req_ready_at_accept", 64'(req_ready), 64'd1);
        req_valid = 1'b1; mem_rd_ena = rd; mem_wr_ena = wr;
        load_info = li; save_info = si; addr = a; wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0; mem_rd_ena = 1'b0; mem_wr_ena = 1'b0;
        if (!exp_err) begin
            bus_ready = 1'b0;
            repeat (nready) begin @(posedge clk); #1; end
            bus_ready = 1'b1;
            @(posedge clk); #1;
            bus_ready = 1'b0;
            if (rd) begin
                repeat (nrvalid) begin @(posedge clk); #1; end
                bus_rvalid = 1'b1; bus_rdata = rdata;
                @(posedge clk); #1;
                bus_rvalid = 1'b0;
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; mem_rd_ena = 1'b0; mem_wr_ena = 1'b0;
        load_info = 7'd0; save_info = 4'd0; addr = 64'd0; wdata = 64'd0;
        bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = 64'd0;
        repeat (2) @(posedge clk); #1;
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_bus_valid", 64'(bus_valid), 64'd0);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_data", resp_data, 64'd0);
        check("rst_bus_addr", bus_addr, 64'd0);
        check("rst_stall", 64'(stall), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // LB 0x1003 -> byte 0x80 sign-extended
        run(1, 0, 7'b0000001, 4'd0, 64'h1003, 64'd0, 0, 0, 64'h0000_0000_8000_0000,
            0, 64'hFFFF_FFFF_FFFF_FF80, 64'h1000, 8'h00, 64'd0);
        // LWU 0x2004 -> upper word zero-extended
        run(1, 0, 7'b1000000, 4'd0, 64'h2004, 64'd0, 0, 0, 64'h8765_4321_0000_0000,
            0, 64'h0000_0000_8765_4321, 64'h2000, 8'h00, 64'd0);
        // SH 0x3006 with two backpressure cycles
        run(0, 1, 7'd0, 4'b0010, 64'h3006, 64'hBEEF, 2, 0, 64'd0,
            0, 64'd0, 64'h3000, 8'hC0, 64'hBEEF_0000_0000_0000);
        // LD 0x4004 misaligned
        run(1, 0, 7'b0001000, 4'd0, 64'h4004, 64'd0, 0, 0, 64'd0,
            1, 64'd0, 64'h0, 8'h00, 64'd0);
        // LH 0x10 with one missing-rvalid cycle
        run(1, 0, 7'b0000010, 4'd0, 64'h10, 64'd0, 0, 1, 64'h0000_0000_0000_F234,
            0, 64'hFFFF_FFFF_FFFF_F234, 64'h10, 8'h00, 64'd0);
        // SW 0x24 -> upper half lanes
        run(0, 1, 7'd0, 4'b0100, 64'h24, 64'hDEAD_BEEF, 0, 0, 64'd0,
            0, 64'd0, 64'h20, 8'hF0, 64'hDEAD_BEEF_0000_0000);
        // Both enables set -> error
        run(1, 1, 7'b0000100, 4'b0100, 64'h0, 64'd0, 0, 0, 64'd0,
            1, 64'd0, 64'h0, 8'h00, 64'd0);
        // load_info not one-hot -> error
        run(1, 0, 7'b0000011, 4'd0, 64'h0, 64'd0, 0, 0, 64'd0,
            1, 64'd0, 64'h0, 8'h00, 64'd0);

        // req_valid with no enable is ignored
        req_valid = 1'b1; load_info = 7'b0000001;
        #3;
        check("ignore_stall", 64'(stall), 64'd0);
        @(posedge clk); #1;
        check("ignore_req_ready", 64'(req_ready), 64'd1);
        req_valid = 1'b0;
        @(posedge clk); #1;

        // Reset while in WAIT_R; the late rvalid must be dropped
        begin
            bus_t b;
            b.addr = 64'h50; b.we = 1'b0; b.wdata = 64'd0; b.strb = 8'h00;
            exp_bus.push_back(b);
            req_valid = 1'b1; mem_rd_ena = 1'b1; load_info = 7'b0000100; addr = 64'h50;
            @(posedge clk); #1;
            req_valid = 1'b0; mem_rd_ena = 1'b0; bus_ready = 1'b1;
            @(posedge clk); #1;
            bus_ready = 1'b0;
            #2 rst_n = 1'b0;
            #1;
            check("abort_bus_valid", 64'(bus_valid), 64'd0);
            check("abort_req_ready", 64'(req_ready), 64'd1);
            check("abort_resp_valid", 64'(resp_valid), 64'd0);
            check("abort_stall", 64'(stall), 64'd0);
            @(posedge clk); #1;
            rst_n = 1'b1; bus_rvalid = 1'b1; bus_rdata = 64'h1234_5678;
            @(posedge clk); #1;
            bus_rvalid = 1'b0;
            repeat (3) begin @(posedge clk); #1; end
            check("post_abort_req_ready", 64'(req_ready), 64'd1);
            check("post_abort_resp_valid", 64'(resp_valid), 64'd0);
        end

        // Back-to-back SD 0x8 then LBU 0x9
        stall_cnt = 0;
        stall_win = 1'b1;
        run(0, 1, 7'd0, 4'b1000, 64'h8, 64'h1122_3344_5566_7788, 0, 0, 64'd0,
            0, 64'd0, 64'h8, 8'hFF, 64'h1122_3344_5566_7788);
        run(1, 0, 7'b0010000, 4'd0, 64'h9, 64'd0, 0, 0, 64'h0000_0000_0000_AB00,
            0, 64'h0000_0000_0000_00AB, 64'h8, 8'h00, 64'd0);
        check("b2b_idle_stall", 64'(stall), 64'd0);
        @(posedge clk); #1;
        stall_win = 1'b0;
        check("b2b_stall_cycles", 64'(stall_cnt), 64'd7);

        repeat (2) @(posedge clk); #1;
        check("resp_queue_drained", 64'(exp_resp.size()), 64'd0);
        check("bus_queue_drained", 64'(exp_bus.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store unit controller for the in-order RV64 core. Accepts one decoded memory access per transaction from the execute stage (ALU-computed address plus decoded load/store flags), drives a single-outstanding valid/ready data-bus transaction, stalls the pipeline while the access is in flight, and returns aligned, sign- or zero-extended load data for write-back. Sits between execute and the data-memory/bus port, ahead of write-back.

## Interface
- No parameters; data width fixed at 64 (`REG_BUS`).
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clk` in 1: core clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: execute stage presents an access this cycle.
- `req_ready` out 1: controller is IDLE and can accept an access.
- `mem_rd_ena` in 1: access is a load.
- `mem_wr_ena` in 1: access is a store.
- `load_info` in 7: one-hot: [0]LB [1]LH [2]LW [3]LD [4]LBU [5]LHU [6]LWU.
- `save_info` in 4: one-hot: [0]SB [1]SH [2]SW [3]SD.
- `addr` in 64: byte address (ALU result).
- `wdata` in 64: store data (rs2), right-justified.
- `stall` out 1: hold the upstream pipeline.
- `bus_valid` out 1: bus request valid.
- `bus_ready` in 1: bus accepts the request.
- `bus_we` out 1: 1 = write.
- `bus_addr` out 64: `{addr[63:3], 3'b0}`.
- `bus_wdata` out 64: store data shifted to its byte lanes.
- `bus_wstrb` out 8: byte-lane write enables; 0 for reads.
- `bus_rvalid` in 1: read data valid.
- `bus_rdata` in 64: aligned 8-byte read data.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_data` out 64: extended load result; 0 for stores and errors.
- `resp_err` out 1: misaligned or illegal access; qualified by `resp_valid`.

## Operation
- States: IDLE, REQ, WAIT_R, RESP.
- IDLE: `req_ready=1`. Acceptance = `req_valid & (mem_rd_ena | mem_wr_ena)`. `req_valid` with neither enable: ignored, state unchanged. On acceptance, register type, size, sign, `addr[2:0]`, shifted wdata and strobe.
  - Misaligned access (H: addr[0]≠0; W: addr[1:0]≠0; D: addr[2:0]≠0), both enables set, or `load_info`/`save_info` not one-hot: go to RESP with `resp_err=1`; no bus transaction.
  - Otherwise go to REQ.
- REQ: `bus_valid=1`, held with `bus_addr`, `bus_we`, `bus_wdata`, `bus_wstrb` stable until `bus_ready`. On handshake: load → WAIT_R; store → RESP.
- WAIT_R: wait for `bus_rvalid`, then latch the extracted result and go to RESP. `bus_rvalid` outside WAIT_R is ignored.
- RESP: `resp_valid=1` for exactly one cycle, then IDLE.
- Load extraction:
  - Shift `bus_rdata` right by `off*8`, where `off` = registered `addr[2:0]`.
  - LB/LH/LW: sign-extend from bit 7/15/31. LBU/LHU/LWU: zero-extend. LD: unchanged.
- Store lanes:
  - Base strobe 8'h01/8'h03/8'h0F/8'hFF for SB/SH/SW/SD.
  - `bus_wstrb` = base << off. `bus_wdata` = `wdata << (off*8)`; bytes outside the strobe are don't-care.
- `stall` = `(state≠IDLE) | (state==IDLE & req_valid & (mem_rd_ena|mem_wr_ena))`. `stall` is 0 in the cycle after RESP, i.e. back in IDLE.

## Timing
- Reset values: `req_ready=1`. All other outputs 0, state IDLE.
- Reset asserted mid-operation: all state aborts immediately and `bus_valid` drops asynchronously. An outstanding read response arriving after reset is ignored.
- Outputs are registered from state and datapath registers, except `req_ready` (decoded from state) and `stall` (combinational on `req_valid`).
- Load, zero wait (`bus_ready` in REQ cycle, `bus_rvalid` in first WAIT_R cycle):
  - Cycle 0 accept, 1 REQ, 2 WAIT_R, 3 RESP `resp_valid`.
  - Latency 3 cycles accept-to-response.
- Store, zero wait: cycle 0 accept, 1 REQ, 2 RESP.
- Error: cycle 0 accept, 1 RESP with `resp_err=1`.
- Each bus backpressure cycle in REQ and each missing-rvalid cycle in WAIT_R adds exactly one cycle.
- Back-to-back: a new access can be accepted in the IDLE cycle directly after RESP. Minimum period: load 4 cycles, store 3 cycles.

## Test plan
- LB at addr 0x1003, `bus_rdata`=0x0000_0000_8000_0000 (byte 3 = 0x80) → `resp_data`=0xFFFF_FFFF_FFFF_FF80 at cycle 3, `bus_addr`=0x1000, `bus_wstrb`=0.
- LWU at 0x2004, `bus_rdata`=0x8765_4321_0000_0000 → `resp_data`=0x0000_0000_8765_4321, `resp_err`=0.
- SH at 0x3006, `wdata`=0xBEEF, `bus_ready` held low 2 cycles → `bus_valid` high 3 cycles with stable `bus_wstrb`=8'hC0 and `bus_wdata[63:48]`=0xBEEF; `resp_valid` 1 cycle after handshake.
- LD at 0x4004 → no `bus_valid`; `resp_valid` with `resp_err=1` one cycle after accept; `resp_data`=0.
- Reset deasserted-to-asserted while in WAIT_R, then `bus_rvalid` pulses → outputs at reset values, `resp_valid` never asserts, `req_ready`=1.
- Back-to-back SD at 0x8 then LBU at 0x9 (`bus_rdata`=0xAB00) → `stall` continuous except the IDLE accept cycles follow directly; second response `resp_data`=0xAB.
